// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and defaults for the serial operand serializer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int SER_W_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-load, shift-right register exposing bit 0.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         bit_out
);

    logic [W-1:0] r_data;

    // Load wins over shift so a reload in the final bit cycle takes effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= r_data >> 1;
        end
    end

    assign bit_out = r_data[0];

endmodule

`default_nettype wire

// File: rtl/serial_operand_serializer.sv
// ============================================================================
// Module      : serial_operand_serializer
// Description : Valid/ready operand pair in, LSB-first bit pairs with framing out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         in_ready,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         first,
    output logic         last
);

    localparam int            C_CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(W - 1);

    ser_state_t       r_state;
    ser_state_t       w_next_state;
    logic [C_CW-1:0]  r_cnt;
    logic             w_shifting;
    logic             w_at_last;
    logic             w_xfer;
    logic             w_bit_a;
    logic             w_bit_b;

    assign w_shifting = (r_state == SHIFT);
    assign w_at_last  = w_shifting && (r_cnt == C_LAST);
    assign in_ready   = rst && (!w_shifting || w_at_last);
    assign w_xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next_state = SHIFT;
            SHIFT:   if (w_at_last) w_next_state = w_xfer ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Counter holds at W-1 after the final bit; only a reload returns it to 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= '0;
        end else if (w_shifting && !w_at_last) begin
            r_cnt <= r_cnt + C_CW'(1);
        end
    end

    piso_shift_reg #(.W(W)) u_sreg_a (
        .clk     (clk),
        .rst     (rst),
        .load    (w_xfer),
        .shift   (w_shifting),
        .din     (in_a),
        .bit_out (w_bit_a)
    );

    piso_shift_reg #(.W(W)) u_sreg_b (
        .clk     (clk),
        .rst     (rst),
        .load    (w_xfer),
        .shift   (w_shifting),
        .din     (in_b),
        .bit_out (w_bit_b)
    );

    always_comb begin
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        if (w_shifting) begin
            bit_valid = 1'b1;
            a         = w_bit_a;
            b         = w_bit_b;
            first     = (r_cnt == '0);
            last      = (r_cnt == C_LAST);
        end
    end

endmodule

`default_nettype wire
